// File: rtl/of_match_arbiter_pkg.sv
// Shared types for the match arbiter: FSM encodings, selection classes, ctrl bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package of_arb_pkg;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_EMIT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_EXACT = 2'd0,
        SEL_WILD  = 2'd1,
        SEL_MISS  = 2'd2
    } sel_class_e;

    // Ctrl bit 0 flags that the action carries an output-port decision.
    localparam int CTRL_OUTPORT_BIT = 0;

    // Exact hit outranks wildcard hit; neither hitting is a miss.
    function automatic sel_class_e classify(input logic exact_hit, input logic wild_hit);
        sel_class_e cls;
        if (exact_hit) begin
            cls = SEL_EXACT;
        end else if (wild_hit) begin
            cls = SEL_WILD;
        end else begin
            cls = SEL_MISS;
        end
        return cls;
    endfunction

endpackage

// File: rtl/of_match_arbiter_if.sv
// Bundle of the two lookup-result inputs and the merged action output.
// Latency: n/a (wires only).
// Backpressure: exact_rdy/wild_rdy towards the tables, out_rdy from the action processor.
interface of_match_arbiter_if #(
    parameter int ACTION_DATA_WIDTH = 256,
    parameter int ACTION_CTRL_WIDTH = 16
) ();
    logic                         exact_valid;
    logic                         exact_hit;
    logic [ACTION_DATA_WIDTH-1:0] exact_action_data;
    logic [ACTION_CTRL_WIDTH-1:0] exact_action_ctrl;
    logic                         exact_rdy;

    logic                         wild_valid;
    logic                         wild_hit;
    logic [ACTION_DATA_WIDTH-1:0] wild_action_data;
    logic [ACTION_CTRL_WIDTH-1:0] wild_action_ctrl;
    logic                         wild_rdy;

    logic                         out_rdy;
    logic [ACTION_DATA_WIDTH-1:0] action_data_bus;
    logic [ACTION_CTRL_WIDTH-1:0] action_ctrl_bus;
    logic                         action_valid;
    logic                         overflow_err;

    // Arbiter side.
    modport slave (
        input  exact_valid, exact_hit, exact_action_data, exact_action_ctrl,
        output exact_rdy,
        input  wild_valid, wild_hit, wild_action_data, wild_action_ctrl,
        output wild_rdy,
        input  out_rdy,
        output action_data_bus, action_ctrl_bus, action_valid, overflow_err
    );

    // Lookup tables plus action processor side.
    modport master (
        output exact_valid, exact_hit, exact_action_data, exact_action_ctrl,
        input  exact_rdy,
        output wild_valid, wild_hit, wild_action_data, wild_action_ctrl,
        input  wild_rdy,
        output out_rdy,
        input  action_data_bus, action_ctrl_bus, action_valid, overflow_err
    );
endinterface

// File: rtl/of_match_arbiter_fifo.sv
// Small fallthrough FIFO: head word is readable combinationally whenever not empty.
// Latency: word written in cycle N is at the head in cycle N+1.
// Backpressure: nearly_full at DEPTH-1 entries; writes while full (without a pop) are dropped.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;
    localparam logic [CW-1:0]             CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]             CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]             CNT_NF   = CW'(DEPTH - 1);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = MAX_DEPTH_BITS'(1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      wr_fire;
    logic                      rd_fire;

    assign full        = (count_q == CNT_FULL);
    assign nearly_full = (count_q >= CNT_NF);
    assign empty       = (count_q == '0);
    assign dout        = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a pop frees the slot a coincident write needs when full.
    always_comb begin
        wr_fire  = wr_en && (!full || rd_en);
        rd_fire  = rd_en && !empty;
        wr_ptr_d = wr_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (wr_fire && !rd_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_fire && rd_fire) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control state register; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/of_match_arbiter.sv
// Pairs exact/wildcard lookup results per packet and emits one action (exact > wild > miss).
// Latency: second result of a pair strobed in cycle N gives action_valid in cycle N+2; one action per 2 cycles.
// Backpressure: out_rdy sampled only before popping a pair; *_rdy drop when an input FIFO is nearly full.
// Optional statistics counters are built when OF_MATCH_ARB_STATS_EN is defined.
module of_match_arbiter
    import of_arb_pkg::*;
#(
    parameter int                           ACTION_DATA_WIDTH = 256,
    parameter int                           ACTION_CTRL_WIDTH = 16,
    parameter logic [ACTION_CTRL_WIDTH-1:0] MISS_ACTION_CTRL  = '0,
    parameter int                           FIFO_DEPTH_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    of_match_arbiter_if.slave     bus
`ifdef OF_MATCH_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [31:0]           exact_hit_cnt,
    output logic [31:0]           wild_hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);
    localparam int D       = ACTION_DATA_WIDTH;
    localparam int C       = ACTION_CTRL_WIDTH;
    localparam int ENTRY_W = 1 + C + D;

    logic [ENTRY_W-1:0] ex_din, ex_head, wd_din, wd_head;
    logic               ex_empty, ex_full, ex_nfull;
    logic               wd_empty, wd_full, wd_nfull;
    logic               pair_ready;
    logic               pop;
    logic               action_valid;
    arb_state_e         state_q, state_d;
    sel_class_e         sel_class;
    logic [D-1:0]       sel_data;
    logic [C-1:0]       sel_ctrl;
    logic [D-1:0]       action_data_q, action_data_d;
    logic [C-1:0]       action_ctrl_q, action_ctrl_d;
    logic               overflow_err_q, overflow_err_d;

    assign ex_din = {bus.exact_hit, bus.exact_action_ctrl, bus.exact_action_data};
    assign wd_din = {bus.wild_hit, bus.wild_action_ctrl, bus.wild_action_data};

    fallthrough_small_fifo #(.WIDTH(ENTRY_W), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_exact_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (ex_din),
        .wr_en       (bus.exact_valid),
        .rd_en       (pop),
        .dout        (ex_head),
        .full        (ex_full),
        .nearly_full (ex_nfull),
        .empty       (ex_empty)
    );

    fallthrough_small_fifo #(.WIDTH(ENTRY_W), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_wild_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (wd_din),
        .wr_en       (bus.wild_valid),
        .rd_en       (pop),
        .dout        (wd_head),
        .full        (wd_full),
        .nearly_full (wd_nfull),
        .empty       (wd_empty)
    );

    assign pair_ready = !ex_empty && !wd_empty && bus.out_rdy;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a complete pair plus downstream room starts a one-cycle emit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (pair_ready) state_d = ST_EMIT;
            ST_EMIT: state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase
    end

    // FSM outputs; gated by reset so a pending emit never leaks a strobe.
    always_comb begin
        pop          = 1'b0;
        action_valid = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_WAIT: pop = pair_ready;
                ST_EMIT: action_valid = 1'b1;
                default: ;
            endcase
        end
    end

    // Winner selection from the two FIFO heads.
    always_comb begin
        sel_class = classify(ex_head[ENTRY_W-1], wd_head[ENTRY_W-1]);
        sel_ctrl  = MISS_ACTION_CTRL;
        sel_data  = '0;
        case (sel_class)
            SEL_EXACT: begin
                sel_ctrl = ex_head[D +: C];
                sel_data = ex_head[D-1:0];
            end
            SEL_WILD: begin
                sel_ctrl = wd_head[D +: C];
                sel_data = wd_head[D-1:0];
            end
            default: ;
        endcase
    end

    // Output word capture on pop, and sticky overflow on a write into a full FIFO.
    always_comb begin
        action_data_d  = pop ? sel_data : action_data_q;
        action_ctrl_d  = pop ? sel_ctrl : action_ctrl_q;
        overflow_err_d = overflow_err_q
                       | (bus.exact_valid && ex_full && !pop)
                       | (bus.wild_valid && wd_full && !pop);
    end

    // Output and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            action_data_q  <= '0;
            action_ctrl_q  <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            action_data_q  <= action_data_d;
            action_ctrl_q  <= action_ctrl_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign bus.exact_rdy       = !ex_nfull;
    assign bus.wild_rdy        = !wd_nfull;
    assign bus.action_valid    = action_valid;
    assign bus.action_data_bus = action_data_q;
    assign bus.action_ctrl_bus = action_ctrl_q;
    assign bus.overflow_err    = overflow_err_q;

`ifdef OF_MATCH_ARB_STATS_EN
    logic [31:0] exact_hit_cnt_q, exact_hit_cnt_d;
    logic [31:0] wild_hit_cnt_q,  wild_hit_cnt_d;
    logic [31:0] miss_cnt_q,      miss_cnt_d;

    // Saturating per-class counters bumped on pop; clear beats a coincident bump.
    always_comb begin
        exact_hit_cnt_d = exact_hit_cnt_q;
        wild_hit_cnt_d  = wild_hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        if (stats_clr) begin
            exact_hit_cnt_d = '0;
            wild_hit_cnt_d  = '0;
            miss_cnt_d      = '0;
        end else if (pop) begin
            case (sel_class)
                SEL_EXACT: if (exact_hit_cnt_q != '1) exact_hit_cnt_d = exact_hit_cnt_q + 32'd1;
                SEL_WILD:  if (wild_hit_cnt_q != '1)  wild_hit_cnt_d  = wild_hit_cnt_q + 32'd1;
                default:   if (miss_cnt_q != '1)      miss_cnt_d      = miss_cnt_q + 32'd1;
            endcase
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            exact_hit_cnt_q <= '0;
            wild_hit_cnt_q  <= '0;
            miss_cnt_q      <= '0;
        end else begin
            exact_hit_cnt_q <= exact_hit_cnt_d;
            wild_hit_cnt_q  <= wild_hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    assign exact_hit_cnt = exact_hit_cnt_q;
    assign wild_hit_cnt  = wild_hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
`endif
endmodule

// File: tb/tb_of_match_arbiter.sv
// Directed bench for of_match_arbiter: priority, latency, ordering, back-pressure, overflow, reset.
// Latency: checks cycle-exact strobe timing.
// Backpressure: drives out_rdy low/high explicitly.
module tb_of_match_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    of_match_arbiter_if #(.ACTION_DATA_WIDTH(256), .ACTION_CTRL_WIDTH(16)) bus_if ();

`ifdef OF_MATCH_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] exact_hit_cnt, wild_hit_cnt, miss_cnt;
`endif

    of_match_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef OF_MATCH_ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .exact_hit_cnt (exact_hit_cnt),
        .wild_hit_cnt  (wild_hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.exact_valid       = 1'b0;
        bus_if.exact_hit         = 1'b0;
        bus_if.exact_action_ctrl = '0;
        bus_if.exact_action_data = '0;
        bus_if.wild_valid        = 1'b0;
        bus_if.wild_hit          = 1'b0;
        bus_if.wild_action_ctrl  = '0;
        bus_if.wild_action_data  = '0;
    endtask

    task automatic drive_exact(input logic hit, input logic [15:0] ctrl, input logic [255:0] data);
        bus_if.exact_valid       = 1'b1;
        bus_if.exact_hit         = hit;
        bus_if.exact_action_ctrl = ctrl;
        bus_if.exact_action_data = data;
    endtask

    task automatic drive_wild(input logic hit, input logic [15:0] ctrl, input logic [255:0] data);
        bus_if.wild_valid       = 1'b1;
        bus_if.wild_hit         = hit;
        bus_if.wild_action_ctrl = ctrl;
        bus_if.wild_action_data = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus_if.out_rdy = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus_if.action_valid); end
        n_checks++; if (bus_if.action_data_bus !== 256'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus_if.action_data_bus); end
        n_checks++; if (bus_if.action_ctrl_bus !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", bus_if.action_ctrl_bus); end
        n_checks++; if (bus_if.overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus_if.overflow_err); end
        n_checks++; if (bus_if.exact_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_exact_rdy: got %b expected 1", bus_if.exact_rdy); end
        n_checks++; if (bus_if.wild_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wild_rdy: got %b expected 1", bus_if.wild_rdy); end
`ifdef OF_MATCH_ARB_STATS_EN
        n_checks++; if ({exact_hit_cnt, wild_hit_cnt, miss_cnt} !== 96'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h/%h expected 0/0/0", exact_hit_cnt, wild_hit_cnt, miss_cnt); end
`endif
        tick();
    endtask

    // Both hit in cycle N: exact wins, strobe at N+2, bus holds afterwards.
    task automatic test_exact_hit();
        drive_exact(1'b1, 16'h0001, 256'h4);
        drive_wild(1'b1, 16'h0001, 256'h8);
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL exact_n0_valid: got %b expected 0", bus_if.action_valid); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL exact_n1_valid: got %b expected 0", bus_if.action_valid); end
        tick();
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b1) begin n_fail++; $display("FAIL exact_n2_valid: got %b expected 1", bus_if.action_valid); end
        n_checks++; if (bus_if.action_data_bus !== 256'h4) begin n_fail++; $display("FAIL exact_data: got %h expected 4", bus_if.action_data_bus); end
        n_checks++; if (bus_if.action_ctrl_bus !== 16'h0001) begin n_fail++; $display("FAIL exact_ctrl: got %h expected 0001", bus_if.action_ctrl_bus); end
`ifdef OF_MATCH_ARB_STATS_EN
        n_checks++; if (exact_hit_cnt !== 32'd1) begin n_fail++; $display("FAIL exact_cnt: got %0d expected 1", exact_hit_cnt); end
`endif
        tick();
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL exact_n3_valid: got %b expected 0", bus_if.action_valid); end
        n_checks++; if (bus_if.action_data_bus !== 256'h4) begin n_fail++; $display("FAIL exact_hold: got %h expected 4", bus_if.action_data_bus); end
        tick();
    endtask

    // Exact miss with a non-zero payload, wildcard hit wins.
    task automatic test_wild_hit();
        drive_exact(1'b0, 16'h0001, 256'h77);
        drive_wild(1'b1, 16'h0001, 256'h2);
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b1) begin n_fail++; $display("FAIL wild_valid: got %b expected 1", bus_if.action_valid); end
        n_checks++; if (bus_if.action_data_bus !== 256'h2) begin n_fail++; $display("FAIL wild_data: got %h expected 2", bus_if.action_data_bus); end
        n_checks++; if (bus_if.action_ctrl_bus !== 16'h0001) begin n_fail++; $display("FAIL wild_ctrl: got %h expected 0001", bus_if.action_ctrl_bus); end
`ifdef OF_MATCH_ARB_STATS_EN
        n_checks++; if (wild_hit_cnt !== 32'd1) begin n_fail++; $display("FAIL wild_cnt: got %0d expected 1", wild_hit_cnt); end
`endif
        tick();
    endtask

    // Both miss with non-zero payloads: fixed miss ctrl and zero data.
    task automatic test_miss();
        drive_exact(1'b0, 16'h0001, 256'h5);
        drive_wild(1'b0, 16'h0001, 256'h9);
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b expected 1", bus_if.action_valid); end
        n_checks++; if (bus_if.action_ctrl_bus !== 16'h0000) begin n_fail++; $display("FAIL miss_ctrl: got %h expected 0000", bus_if.action_ctrl_bus); end
        n_checks++; if (bus_if.action_data_bus !== 256'h0) begin n_fail++; $display("FAIL miss_data: got %h expected 0", bus_if.action_data_bus); end
`ifdef OF_MATCH_ARB_STATS_EN
        n_checks++; if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL miss_cnt: got %0d expected 1", miss_cnt); end
`endif
        tick();
    endtask

    // Exact results at 0..2, wildcard at 10..12: strobes at 12, 14, 16 in packet order.
    task automatic test_back_to_back();
        logic         exp_v;
        logic [255:0] exp_d;
        int           k = 0;
        for (int c = 0; c < 18; c++) begin
            idle_inputs();
            if (c <= 2) drive_exact(1'b1, 16'h0001, 256'h10 + 256'(c));
            if (c >= 10 && c <= 12) drive_wild(1'b1, 16'h0001, 256'h99);
            @(negedge clk);
            exp_v = (c == 12) || (c == 14) || (c == 16);
            n_checks++; if (bus_if.action_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, bus_if.action_valid, exp_v); end
            if (exp_v) begin
                exp_d = 256'h10 + 256'(k);
                k++;
                n_checks++; if (bus_if.action_data_bus !== exp_d) begin n_fail++; $display("FAIL b2b_data c=%0d: got %h expected %h", c, bus_if.action_data_bus, exp_d); end
            end
            tick();
        end
        idle_inputs();
`ifdef OF_MATCH_ARB_STATS_EN
        n_checks++; if (exact_hit_cnt !== 32'd4) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 4", exact_hit_cnt); end
`endif
    endtask

`ifdef OF_MATCH_ARB_STATS_EN
    // Clear coincides with a pop: counters end at zero, strobe still occurs.
    task automatic test_stats_clr();
        drive_exact(1'b0, 16'h0001, 256'h1);
        drive_wild(1'b0, 16'h0001, 256'h1);
        tick();
        idle_inputs();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b1) begin n_fail++; $display("FAIL clr_valid: got %b expected 1", bus_if.action_valid); end
        n_checks++; if ({exact_hit_cnt, wild_hit_cnt, miss_cnt} !== 96'h0) begin n_fail++; $display("FAIL clr_counters: got %h/%h/%h expected 0/0/0", exact_hit_cnt, wild_hit_cnt, miss_cnt); end
        tick();
    endtask
`endif

    // Loaded pair held off by out_rdy=0 for 20 cycles; rise at T gives strobe at T+1.
    task automatic test_backpressure();
        bus_if.out_rdy = 1'b0;
        drive_exact(1'b0, 16'h0001, 256'h0);
        drive_wild(1'b1, 16'h0001, 256'h33);
        tick();
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hold i=%0d: got %b expected 0", i, bus_if.action_valid); end
            tick();
        end
        bus_if.out_rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL bp_t_valid: got %b expected 0", bus_if.action_valid); end
        tick();
        bus_if.out_rdy = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b1) begin n_fail++; $display("FAIL bp_t1_valid: got %b expected 1", bus_if.action_valid); end
        n_checks++; if (bus_if.action_data_bus !== 256'h33) begin n_fail++; $display("FAIL bp_data: got %h expected 33", bus_if.action_data_bus); end
        tick();
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL bp_t2_valid: got %b expected 0", bus_if.action_valid); end
        bus_if.out_rdy = 1'b1;
        tick();
    endtask

    // Reset during the emit cycle suppresses the strobe and clears the output word.
    task automatic test_reset_mid();
        drive_exact(1'b1, 16'h0001, 256'h55);
        drive_wild(1'b1, 16'h0001, 256'h66);
        tick();
        idle_inputs();
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", bus_if.action_valid); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_if.action_data_bus !== 256'h0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", bus_if.action_data_bus); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_after i=%0d: got %b expected 0", i, bus_if.action_valid); end
            tick();
        end
    endtask

    // Four exact results fill the FIFO, a fifth overflows; reset clears the flag and flushes.
    task automatic test_overflow();
        for (int c = 0; c < 4; c++) begin
            drive_exact(1'b1, 16'h0001, 256'hA0 + 256'(c));
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus_if.exact_rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy: got %b expected 0", bus_if.exact_rdy); end
        n_checks++; if (bus_if.overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b expected 0", bus_if.overflow_err); end
        drive_exact(1'b1, 16'h0001, 256'hEE);
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus_if.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus_if.overflow_err); end
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (bus_if.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus_if.overflow_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_if.overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus_if.overflow_err); end
        n_checks++; if (bus_if.exact_rdy !== 1'b1) begin n_fail++; $display("FAIL ovf_rdy_after: got %b expected 1", bus_if.exact_rdy); end
        drive_wild(1'b1, 16'h0001, 256'h44);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (bus_if.action_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_flush i=%0d: got %b expected 0", i, bus_if.action_valid); end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        bus_if.out_rdy = 1'b1;
        test_reset();
        test_exact_hit();
        test_wild_hit();
        test_miss();
        test_back_to_back();
`ifdef OF_MATCH_ARB_STATS_EN
        test_stats_clr();
`endif
        test_backpressure();
        test_reset_mid();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/of_match_arbiter.md
# of_match_arbiter

Merges per-packet lookup results from the exact-match and wildcard tables into the single action stream consumed by the action processor. Both tables return exactly one result per packet, in packet order. The arbiter pairs the two results for each packet and picks the winner: exact hit first, then wildcard hit, then a fixed miss action. It emits one action word per packet onto the action bus and respects downstream back-pressure.

## Interface
- ACTION_DATA_WIDTH, 256, width of action data word
- ACTION_CTRL_WIDTH, 16, width of action ctrl word (bit 0 = output-port action present)
- MISS_ACTION_CTRL, 16'h0000, ctrl word emitted on miss (0 = drop)
- FIFO_DEPTH_BITS, 2, log2 depth of each input result FIFO
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- exact_valid  in  1  exact-table result strobe, one per packet
- exact_hit  in  1  exact-table hit flag
- exact_action_data / exact_action_ctrl  in  ACTION_DATA_WIDTH / ACTION_CTRL_WIDTH  exact-table action
- exact_rdy  out  1  exact FIFO not nearly full
- wild_valid, wild_hit, wild_action_data, wild_action_ctrl, wild_rdy  same shapes, wildcard table
- out_rdy  in  1  downstream action FIFO can accept a word
- action_data_bus  out  ACTION_DATA_WIDTH  selected action data
- action_ctrl_bus  out  ACTION_CTRL_WIDTH  selected action ctrl
- action_valid  out  1  one-cycle strobe per packet
- overflow_err  out  1  sticky; a result was written while its FIFO was full
- stats_clr  in  1  clear statistics counters (stats build only)
- exact_hit_cnt, wild_hit_cnt, miss_cnt  out  32 each  statistics (stats build only)

## Operation
- Each input is buffered in its own fallthrough FIFO of depth 2^FIFO_DEPTH_BITS. Stored word is {hit, ctrl, data}. Write when *_valid=1.
- *_rdy = !nearly_full. Upstream must not strobe while *_rdy=0. A strobe into a full FIFO is dropped and sets overflow_err until reset.
- FSM, two states:
  - WAIT (reset state): if both FIFOs are non-empty and out_rdy=1, pop both in the same cycle, latch the selection, and go to EMIT. Otherwise hold.
  - EMIT: action_valid=1 for exactly this cycle, then return to WAIT.
- Selection rule:
  - exact_hit=1: use the exact ctrl/data. The wildcard entry is discarded.
  - otherwise wild_hit=1: use the wildcard ctrl/data.
  - otherwise: ctrl=MISS_ACTION_CTRL, data=0.
- A non-empty FIFO with an empty partner waits indefinitely. Results are never emitted unpaired.
- action_data_bus and action_ctrl_bus are registered and hold their value after EMIT until the next selection.
- Reset mid-operation: both FIFOs are flushed and the FSM returns to WAIT. A pending EMIT is cancelled; no partial strobe.

## Timing
- Reset values: action_valid=0, action_data_bus=0, action_ctrl_bus=0, overflow_err=0, counters=0, exact_rdy and wild_rdy=1 from the first cycle after reset deasserts.
- Latency: second result strobed at cycle N is visible at FIFO head at N+1, popped at N+1 if out_rdy=1, and action_valid=1 at N+2.
- Throughput: one action every 2 cycles (packets are ≥2 bus words).
- out_rdy is sampled only in WAIT. Once popped, EMIT completes even if out_rdy drops. The downstream nearly-full margin covers this one word.
- A write and a pop on the same FIFO in the same cycle are legal. Occupancy is unchanged.

## Configuration
- OF_MATCH_ARB_STATS_EN defined:
  - Three 32-bit counters increment in the WAIT→EMIT cycle, by selection class.
  - Counters saturate at 32'hFFFF_FFFF.
  - stats_clr=1 zeroes all three. Clear wins over a coincident increment, and that event is not counted.
- Undefined: counters, stats_clr and *_cnt ports are absent. Arbitration is unchanged.

## Structure
- Shared package of_arb_pkg holds:
  - FSM state encodings ST_WAIT=0, ST_EMIT=1.
  - Selection class codes SEL_EXACT, SEL_WILD, SEL_MISS.
  - Default ctrl bit positions (CTRL_OUTPORT_BIT=0).
- One sub-module, instantiated twice: existing fallthrough_small_fifo, WIDTH = 1+ACTION_CTRL_WIDTH+ACTION_DATA_WIDTH.

## Test plan
- Exact hit ctrl=16'h0001, data[15:0]=16'h0004; wildcard hit ctrl=16'h0001, data[15:0]=16'h0008, same cycle N → action_valid at N+2 with data[15:0]=16'h0004, exact_hit_cnt=1.
- Exact miss, wildcard hit ctrl=16'h0001, data[15:0]=16'h0002 → data[15:0]=16'h0002, wild_hit_cnt=1.
- Both miss → action_ctrl_bus=MISS_ACTION_CTRL, data=0, miss_cnt=1.
- Exact results for 3 packets at cycles 0–2, wildcard results at cycles 10–12 → three strobes at 12, 14, 16, in order. No strobe before cycle 12.
- out_rdy=0 with both FIFOs loaded for 20 cycles → no strobe. out_rdy rises at cycle T → action_valid at T+1.
- Fill exact FIFO to depth 4, then strobe again → exact_rdy=0 beforehand and overflow_err=1 sticky. Assert reset → overflow_err=0 and no strobe.
